ptr_secded_pipe: RTL and testbench
==================================

PTR_SECDED_PIPE -- requirements
Module: ptr_secded_pipe

Interface
REQ-001 SHALL have parameter DATA_W, default 10, meaning decoded pointer width.
REQ-002 SHALL have parameter PAR_W, default 4, meaning Hamming check-bit count; legal only if 2^PAR_W >= DATA_W+PAR_W+1.
REQ-003 SHALL have parameter CNT_W, default 8, meaning error-counter width.
REQ-004 SHALL derive ENC_W = DATA_W+PAR_W+1, the SECDED codeword width.
REQ-005 SHALL have one clock and an asynchronous, active-low reset: clk input 1 (rising-edge clock), then rst_n input 1 (asynchronous active-low reset).
REQ-006 SHALL have ports: in_valid input 1 (codeword valid); in_ready output 1 (codeword accepted when high with in_valid); enc_data input ENC_W (codeword).
REQ-007 SHALL have ports: out_valid output 1; out_ready input 1; out_data output DATA_W (corrected pointer); out_sec output 1 (single error corrected); out_ded output 1 (uncorrectable error); out_syn output PAR_W (syndrome).
REQ-008 SHALL have ports: sec_cnt output CNT_W; ded_cnt output CNT_W; ded_sticky output 1; clr_cnt input 1 (synchronous clear of counters and sticky flag).

Function
REQ-009 SHALL use this codeword layout: bit i (0..ENC_W-2) is Hamming position i+1; check bits sit at positions 2^k; data bits fill the remaining positions in ascending order, LSB first; bit ENC_W-1 is overall even parity over bits 0..ENC_W-2.
REQ-010 SHALL compute syndrome S as the XOR of the position numbers of all set bits at positions 1..ENC_W-1, and P as the XOR of all ENC_W bits.
REQ-011 SHALL classify each word as follows: S=0, P=0 -> clean; P=1 with S=0 -> overall-parity-bit error, out_sec=1, data unchanged; P=1 with 1<=S<=ENC_W-1 -> flip position S, out_sec=1; P=1 with S>ENC_W-1 -> out_ded=1; S!=0 with P=0 -> out_ded=1.
REQ-012 SHALL, when out_ded=1, output uncorrected extracted data; out_sec and out_ded SHALL never both be 1.
REQ-013 SHALL be a 2-stage pipeline: stage 1 registers codeword, S and P; stage 2 registers corrected data and flags; latency is 2 cycles from the accepting edge to out_valid with no stall.
REQ-014 SHALL load stage 2 when !s2_valid || out_ready, and load stage 1 when !s1_valid || stage-2 load.
REQ-015 SHALL drive in_ready = !s1_valid || !s2_valid || out_ready, combinationally.
REQ-016 SHALL sustain full throughput (1 word/cycle) while out_ready=1, and SHALL never drop, duplicate or reorder words under backpressure.
REQ-017 SHALL hold out_data/out_sec/out_ded/out_syn stable while out_valid=1 and out_ready=0.
REQ-018 SHALL increment sec_cnt on an output handshake (out_valid && out_ready) with out_sec=1, and ded_cnt on a handshake with out_ded=1; both counters saturate at 2^CNT_W-1.
REQ-019 SHALL set ded_sticky on a handshake with out_ded=1 and hold it until clr_cnt or reset.
REQ-020 SHALL give clr_cnt priority over a same-cycle increment: counters = 0 and ded_sticky = 0 after that edge, and the coincident event is not counted.

Reset
REQ-021 SHALL, while rst_n=0, clear s1_valid, s2_valid, out_valid, out_data, out_sec, out_ded, out_syn, sec_cnt, ded_cnt and ded_sticky to 0 immediately, independent of clk.
REQ-022 SHALL discard in-flight words on reset mid-operation; in_ready SHALL be 1 on the first cycle after rst_n deasserts.

Verification (DATA_W=10, PAR_W=4, ENC_W=15)
REQ-023 SHALL verify clean word: enc_data=15'h0000 accepted at edge N -> out_valid at edge N+2, out_data=10'h000, out_sec=0, out_ded=0, out_syn=0.
REQ-024 SHALL verify single data error: all-zero codeword with bit 2 flipped (position 3, data bit 0) -> out_data=10'h000, out_sec=1, out_syn=3, sec_cnt=1.
REQ-025 SHALL verify double error: all-zero codeword with bits 0 and 1 flipped -> out_syn=3, out_ded=1, out_sec=0, out_data=10'h000, ded_cnt=1, ded_sticky=1.
REQ-026 SHALL verify backpressure: out_ready=0 while 3 words are offered back-to-back -> 2 words accepted, then in_ready=0; after out_ready=1, all 3 words emerge in order with no loss.
REQ-027 SHALL verify saturation and clear: with CNT_W=2, 5 single-error words -> sec_cnt=3; clr_cnt pulsed coincident with a 6th single-error handshake -> sec_cnt=0.
REQ-028 SHALL verify reset mid-operation: rst_n low with both stages full -> out_valid=0 and counters=0 asynchronously; no stale word appears after release.

Source files
------------

// File: rtl/ptr_secded_pipe.sv
// Purpose: SECDED (extended Hamming) decode of a protected pointer, with error counters.
// Latency: 2 cycles (stage 1 = codeword/syndrome/parity, stage 2 = corrected data/flags).
// Backpressure: valid/ready; stages advance only when the downstream slot is free or draining.
module ptr_secded_pipe #(
  parameter int DATA_W = 10,
  parameter int PAR_W  = 4,
  parameter int CNT_W  = 8,
  localparam int ENC_W = DATA_W + PAR_W + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ENC_W-1:0]  enc_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_sec,
  output logic              out_ded,
  output logic [PAR_W-1:0]  out_syn,
  output logic [CNT_W-1:0]  sec_cnt,
  output logic [CNT_W-1:0]  ded_cnt,
  output logic              ded_sticky,
  input  logic              clr_cnt
);

  // Highest Hamming position that exists in the codeword; larger syndromes are uncorrectable.
  localparam logic [PAR_W-1:0] MAX_POS = PAR_W'(ENC_W - 1);

  // Syndrome: XOR of the position numbers (1-based) of every set bit below the parity bit.
  function automatic logic [PAR_W-1:0] calc_syn(input logic [ENC_W-1:0] cw);
    logic [ENC_W-1:0] sh;
    logic [PAR_W-1:0] s;
    sh = cw;
    s  = '0;
    for (int p = 1; p < ENC_W; p++) begin
      if (sh[0]) s = s ^ PAR_W'(p);
      sh = sh >> 1;
    end
    return s;
  endfunction

  // Pull the data bits out of the non-power-of-two positions, lowest position -> data LSB.
  // Bits are shifted in from the top so the first data position ends up at bit 0.
  function automatic logic [DATA_W-1:0] extract(input logic [ENC_W-1:0] cw);
    logic [ENC_W-1:0]  sh;
    logic [DATA_W-1:0] d;
    sh = cw;
    d  = '0;
    for (int p = 1; p < ENC_W; p++) begin
      if ((p & (p - 1)) != 0) d = {sh[0], d[DATA_W-1:1]};
      sh = sh >> 1;
    end
    return d;
  endfunction

  logic              s1_valid;
  logic [ENC_W-1:0]  s1_code;
  logic [PAR_W-1:0]  s1_syn;
  logic              s1_par;
  logic              s2_valid;
  logic              s1_load;
  logic              s2_load;
  logic              s1_fix;
  logic              s1_ded;
  logic [ENC_W-1:0]  s1_flip;
  logic [DATA_W-1:0] s2_data_nxt;
  logic              out_hs;

  assign s2_load   = !s2_valid || out_ready;
  assign s1_load   = !s1_valid || s2_load;
  assign in_ready  = s1_load;
  assign out_valid = s2_valid;
  assign out_hs    = s2_valid && out_ready;

  // Classify stage-1 word and build the single-bit correction mask.
  // A parity error with S=0 hits only the overall parity bit, so the mask is empty.
  always_comb begin
    s1_fix      = s1_par && (s1_syn <= MAX_POS);
    s1_ded      = (!s1_par && (s1_syn != '0)) || (s1_par && (s1_syn > MAX_POS));
    s1_flip     = '0;
    if (s1_fix) s1_flip = (ENC_W'(1) << s1_syn) >> 1;
    s2_data_nxt = extract(s1_code ^ s1_flip);
  end

  // Stage 1: capture the codeword with its syndrome and overall parity.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_code  <= '0;
      s1_syn   <= '0;
      s1_par   <= 1'b0;
    end else if (s1_load) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_code <= enc_data;
        s1_syn  <= calc_syn(enc_data);
        s1_par  <= ^enc_data;
      end
    end
  end

  // Stage 2: register corrected data and flags; held while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      out_data <= '0;
      out_sec  <= 1'b0;
      out_ded  <= 1'b0;
      out_syn  <= '0;
    end else if (s2_load) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        out_data <= s2_data_nxt;
        out_sec  <= s1_fix;
        out_ded  <= s1_ded;
        out_syn  <= s1_syn;
      end
    end
  end

  // Saturating error counters and sticky DED flag, counted on output handshakes; clear wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sec_cnt    <= '0;
      ded_cnt    <= '0;
      ded_sticky <= 1'b0;
    end else if (clr_cnt) begin
      sec_cnt    <= '0;
      ded_cnt    <= '0;
      ded_sticky <= 1'b0;
    end else if (out_hs) begin
      if (out_sec && (sec_cnt != {CNT_W{1'b1}})) sec_cnt <= sec_cnt + 1'b1;
      if (out_ded && (ded_cnt != {CNT_W{1'b1}})) ded_cnt <= ded_cnt + 1'b1;
      if (out_ded) ded_sticky <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ptr_secded_pipe.sv
// Purpose: self-checking bench for ptr_secded_pipe (DATA_W=10, PAR_W=4, CNT_W=2).
// Latency: expected words are queued at acceptance and compared at each output handshake.
// Backpressure: out_ready is stalled and toggled to exercise hold, ordering and in_ready.
module tb_ptr_secded_pipe;

  localparam int DW = 10;
  localparam int PW = 4;
  localparam int CW = 2;
  localparam int EW = DW + PW + 1;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          sec;
    logic          ded;
    logic [PW-1:0] syn;
  } exp_t;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [EW-1:0] enc_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_sec;
  logic          out_ded;
  logic [PW-1:0] out_syn;
  logic [CW-1:0] sec_cnt;
  logic [CW-1:0] ded_cnt;
  logic          ded_sticky;
  logic          clr_cnt;

  int checks   = 0;
  int failures = 0;
  int out_cnt  = 0;
  int rdy_cnt  = 0;
  bit toggle_rdy = 0;

  exp_t exp_q[$];
  int   m_sec, m_ded;
  bit   m_sticky;
  bit   hold_vld;
  logic [15:0] hold_val;

  ptr_secded_pipe #(.DATA_W(DW), .PAR_W(PW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .enc_data(enc_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_sec(out_sec), .out_ded(out_ded), .out_syn(out_syn),
    .sec_cnt(sec_cnt), .ded_cnt(ded_cnt), .ded_sticky(ded_sticky),
    .clr_cnt(clr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s bound expired", name);
  endtask

  // Reference encoder: data in non-power-of-two positions, check bit k makes every
  // position with bit k set have even parity, then overall even parity on top.
  function automatic logic [EW-1:0] encode(input logic [DW-1:0] d);
    logic [EW-1:0] cw;
    int k;
    logic par;
    cw = '0;
    k  = 0;
    for (int p = 1; p < EW; p++) begin
      if ((p & (p - 1)) != 0) begin
        cw[p-1] = d[k];
        k++;
      end
    end
    for (int j = 0; j < PW; j++) begin
      par = 1'b0;
      for (int p = 1; p < EW; p++)
        if (((p >> j) & 1) == 1) par = par ^ cw[p-1];
      cw[(1 << j) - 1] = par;
    end
    cw[EW-1] = ^cw[EW-2:0];
    return cw;
  endfunction

  function automatic logic [DW-1:0] raw_data(input logic [EW-1:0] w);
    logic [DW-1:0] d;
    int k;
    d = '0;
    k = 0;
    for (int p = 1; p < EW; p++) begin
      if ((p & (p - 1)) != 0) begin
        d[k] = w[p-1];
        k++;
      end
    end
    return d;
  endfunction

  // Nearest-codeword decoder: clean if the word is a codeword, corrected if exactly one
  // codeword lies at Hamming distance 1, otherwise uncorrectable with raw data.
  function automatic exp_t model(input logic [EW-1:0] w);
    exp_t e;
    int best;
    logic [EW-1:0] diff;
    e.syn = '0;
    for (int p = 1; p < EW; p++)
      if (w[p-1]) e.syn = e.syn ^ PW'(p);
    e.data = raw_data(w);
    e.sec  = 1'b0;
    e.ded  = 1'b0;
    if (encode(e.data) != w) begin
      best = -1;
      for (int d = 0; d < (1 << DW); d++) begin
        diff = encode(DW'(d)) ^ w;
        if ($countones(diff) == 1) best = d;
      end
      if (best >= 0) begin
        e.sec  = 1'b1;
        e.data = DW'(best);
      end else begin
        e.ded = 1'b1;
      end
    end
    return e;
  endfunction

  // Compare process: counters every cycle, output fields on every handshake, hold stability.
  always @(negedge clk) begin
    exp_t e;
    bit hs;
    if (!rst_n) begin
      exp_q.delete();
      m_sec = 0; m_ded = 0; m_sticky = 0; hold_vld = 0;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_counters", {sec_cnt, ded_cnt, ded_sticky}, 0);
    end else begin
      chk("sec_cnt", sec_cnt, m_sec);
      chk("ded_cnt", ded_cnt, m_ded);
      chk("ded_sticky", ded_sticky, m_sticky);
      if (hold_vld) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_fields", {out_data, out_sec, out_ded, out_syn}, hold_val);
      end
      hs = out_valid && out_ready;
      e  = '0;
      if (hs) begin
        out_cnt++;
        if (exp_q.size() == 0) begin
          fail_now("unexpected_output");
        end else begin
          e = exp_q.pop_front();
          chk("out_data", out_data, e.data);
          chk("out_sec", out_sec, e.sec);
          chk("out_ded", out_ded, e.ded);
          chk("out_syn", out_syn, e.syn);
        end
      end
      if (clr_cnt) begin
        m_sec = 0; m_ded = 0; m_sticky = 0;
      end else if (hs) begin
        if (e.sec && m_sec < (1 << CW) - 1) m_sec++;
        if (e.ded && m_ded < (1 << CW) - 1) m_ded++;
        if (e.ded) m_sticky = 1;
      end
      hold_vld = out_valid && !out_ready;
      hold_val = {out_data, out_sec, out_ded, out_syn};
      if (in_valid && in_ready) exp_q.push_back(model(enc_data));
    end
  end

  task automatic send(input logic [EW-1:0] w);
    bit acc;
    int n;
    in_valid = 1'b1;
    enc_data = w;
    acc = 0;
    n = 0;
    while (!acc && n < 100) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
      if (toggle_rdy) begin
        rdy_cnt++;
        out_ready = (rdy_cnt % 3) != 0;
      end
      n++;
    end
    in_valid = 1'b0;
    if (!acc) fail_now("send_timeout");
  endtask

  task automatic drain();
    bit done;
    done = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 60 && !done; i++) begin
      @(posedge clk); #1;
      if (exp_q.size() == 0 && !out_valid) done = 1;
    end
    if (!done) fail_now("drain_timeout");
  endtask

  // One cycle to reach stage 2, then the word is visible at the following negedge.
  task automatic to_output();
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] sd [12];
    int            e1 [12];
    int            e2 [12];
    logic [EW-1:0] w;
    logic [EW-1:0] one;
    logic [EW-1:0] bw [3];
    int idx, base, stale;
    bit acc, seen;

    sd = '{10'h3FF, 10'h155, 10'h2AA, 10'h001, 10'h200, 10'h0F0,
           10'h30C, 10'h123, 10'h3C3, 10'h07E, 10'h246, 10'h1B9};
    e1 = '{-1, 0, 14, 5, -1, 13, 3, 7, 2, -1, 9, 1};
    e2 = '{-1, -1, -1, -1, -1, -1, 8, -1, 14, -1, 11, -1};
    one = 15'd1;

    rst_n = 1'b0; in_valid = 1'b0; enc_data = '0; out_ready = 1'b0; clr_cnt = 1'b0;
    #3;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_fields", {out_data, out_sec, out_ded, out_syn}, 0);
    chk("reset_counters", {sec_cnt, ded_cnt, ded_sticky}, 0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("in_ready_after_reset", in_ready, 1);

    // Pin the reference encoder to hand-derived codewords.
    chk("model_enc_001", encode(10'h001), 15'h4007);
    chk("model_enc_200", encode(10'h200), 15'h208A);
    chk("model_dec_ded", model(15'h0003), {10'h000, 1'b0, 1'b1, 4'h3});

    // Clean word: not visible one cycle after acceptance, visible the next.
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(15'h0000);
    @(negedge clk);
    chk("lat_clean_early", out_valid, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("lat_clean_valid", out_valid, 1);
    chk("clean_fields", {out_data, out_sec, out_ded, out_syn}, 0);
    @(posedge clk); #1;

    // Single error on data bit 0 (position 3).
    send(15'h0004);
    to_output();
    chk("sec_valid", out_valid, 1);
    chk("sec_fields", {out_data, out_sec, out_ded, out_syn}, {10'h000, 1'b1, 1'b0, 4'h3});
    @(posedge clk); #1;
    @(negedge clk);
    chk("sec_cnt_one", sec_cnt, 1);
    @(posedge clk); #1;

    // Double error on positions 1 and 2.
    send(15'h0003);
    to_output();
    chk("ded_fields", {out_data, out_sec, out_ded, out_syn}, {10'h000, 1'b0, 1'b1, 4'h3});
    @(posedge clk); #1;
    @(negedge clk);
    chk("ded_cnt_one", ded_cnt, 1);
    chk("ded_sticky_set", ded_sticky, 1);
    @(posedge clk); #1;

    // Directed stream with errors, out_ready toggling under the model.
    send(15'h4007);
    send(15'h208A);
    toggle_rdy = 1;
    for (int i = 0; i < 12; i++) begin
      w = encode(sd[i]);
      if (e1[i] >= 0) w = w ^ (one << e1[i]);
      if (e2[i] >= 0) w = w ^ (one << e2[i]);
      send(w);
    end
    toggle_rdy = 0;
    drain();

    // Backpressure: three back-to-back words against a stalled output.
    bw[0] = encode(10'h011); bw[1] = encode(10'h022) ^ 15'h0010; bw[2] = encode(10'h033);
    base = out_cnt;
    out_ready = 1'b0;
    idx = 0;
    in_valid = 1'b1;
    enc_data = bw[0];
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
      if (acc) begin
        idx++;
        if (idx < 3) enc_data = bw[idx];
        else in_valid = 1'b0;
      end
    end
    chk("bp_accepted", idx, 2);
    @(negedge clk);
    chk("bp_in_ready_low", in_ready, 0);
    chk("bp_out_valid", out_valid, 1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int c = 0; c < 20 && idx < 3; c++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
      if (acc) begin
        idx++;
        in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    chk("bp_all_accepted", idx, 3);
    drain();
    chk("bp_out_count", out_cnt - base, 3);

    // Saturation at 3 with CNT_W=2, then clear coincident with a counted handshake.
    clr_cnt = 1'b1;
    @(posedge clk); #1;
    clr_cnt = 1'b0;
    for (int k = 0; k < 5; k++) send(encode(10'h0C5) ^ (one << (k + 2)));
    drain();
    @(negedge clk);
    chk("sat_sec_cnt", sec_cnt, 3);
    @(posedge clk); #1;
    out_ready = 1'b0;
    send(encode(10'h05A) ^ 15'h0100);
    seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      seen = out_valid;
    end
    if (!seen) fail_now("clr_wait_valid");
    @(posedge clk); #1;
    out_ready = 1'b1;
    clr_cnt = 1'b1;
    @(posedge clk); #1;
    clr_cnt = 1'b0;
    @(negedge clk);
    chk("clr_coincident_sec", sec_cnt, 0);
    chk("clr_coincident_sticky", ded_sticky, 0);
    @(posedge clk); #1;

    // Reset with both stages full: outputs and counters drop without a clock edge.
    send(encode(10'h155) ^ 15'h0010);
    send(15'h0003);
    drain();
    @(negedge clk);
    chk("pre_rst_sec", sec_cnt, 1);
    chk("pre_rst_sticky", ded_sticky, 1);
    @(posedge clk); #1;
    out_ready = 1'b0;
    send(encode(10'h0AA));
    send(encode(10'h155));
    @(negedge clk);
    chk("pre_rst_full", out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", out_valid, 0);
    chk("async_rst_counters", {sec_cnt, ded_cnt, ded_sticky}, 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("in_ready_post_rst", in_ready, 1);
    stale = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    chk("no_stale_word", stale, 0);
    chk("final_queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
